bcd_updown_counter: RTL and testbench

Synchronous 4-bit up/down counter with parallel load, count enable and terminal-count output, built from rising-edge D flip-flops with asynchronous clear. It consumes the flip-flop stage directly: four flip-flops hold the count and gate-level next-state logic feeds their D inputs. Default modulus is 10 (BCD digit), so TC can be chained into the EN of the next decade.

---
 rtl/bcd_updown_counter_if.sv | 21 ++
 rtl/bcd_updown_counter.sv | 75 +++++++
 tb/tb_bcd_updown_counter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle for bcd_updown_counter: count controls and load data in,
// count value, its complement and terminal count out.
interface bcd_updown_counter_if;
  logic       EN;
  logic       UP;
  logic       LD;
  logic [3:0] DIN;
  logic [3:0] Q;
  logic [3:0] Qnot;
  logic       TC;

  modport master (
    output EN, UP, LD, DIN,
    input  Q, Qnot, TC
  );

  modport slave (
    input  EN, UP, LD, DIN,
    output Q, Qnot, TC
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Modulo-N up/down counter (default BCD digit) with synchronous load, count enable
// and combinational terminal count for decade chaining.
module bcd_updown_counter #(
  parameter int MODULUS = 10
) (
  input logic                 C,
  input logic                 REnot,
  bcd_updown_counter_if.slave bus
);

  localparam logic [3:0] MAX_C = 4'(MODULUS - 1);

  logic [3:0] q_r;
  logic [3:0] qn_r;
  logic [3:0] d_s;
  logic       tc_s;

  // Count flops: true and complement outputs, both cleared asynchronously
  always_ff @(posedge C or negedge REnot) begin
    if (!REnot) begin
      q_r  <= 4'd0;
      qn_r <= 4'hF;
    end else begin
      q_r  <= d_s;
      qn_r <= ~d_s;
    end
  end

  // Next count: load beats enable; out-of-range load data is replaced by zero
  always_comb begin
    d_s = q_r;
    if (bus.LD) begin
      if (bus.DIN <= MAX_C) begin
        d_s = bus.DIN;
      end else begin
        d_s = 4'd0;
      end
    end else if (bus.EN) begin
      if (bus.UP) begin
        if (q_r == MAX_C) begin
          d_s = 4'd0;
        end else begin
          d_s = q_r + 4'd1;
        end
      end else begin
        if (q_r == 4'd0) begin
          d_s = MAX_C;
        end else begin
          d_s = q_r - 4'd1;
        end
      end
    end else begin
      d_s = q_r;
    end
  end

  // Terminal count follows EN/UP/Q without a register so decades chain in one cycle
  always_comb begin
    tc_s = 1'b0;
    if (bus.EN) begin
      if (bus.UP) begin
        tc_s = (q_r == MAX_C);
      end else begin
        tc_s = (q_r == 4'd0);
      end
    end else begin
      tc_s = 1'b0;
    end
  end

  assign bus.Q    = q_r;
  assign bus.Qnot = qn_r;
  assign bus.TC   = tc_s;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench: a MODULUS=10 counter plus a chained pair of
// MODULUS=16 counters (low counter's TC drives the high counter's EN).
module tb_bcd_updown_counter;

  logic C;
  logic REnot;
  int   n_cmp;
  int   n_bad;

  bcd_updown_counter_if bus10 ();
  bcd_updown_counter_if bus16 ();
  bcd_updown_counter_if busb ();

  assign busb.EN = bus16.TC;

  bcd_updown_counter #(.MODULUS(10)) dut (.C(C), .REnot(REnot), .bus(bus10));
  bcd_updown_counter #(.MODULUS(16)) dut16 (.C(C), .REnot(REnot), .bus(bus16));
  bcd_updown_counter #(.MODULUS(16)) dut16b (.C(C), .REnot(REnot), .bus(busb));

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic drv(input logic ld, input logic en, input logic up, input logic [3:0] din);
    @(negedge C);
    bus10.LD  = ld;
    bus10.EN  = en;
    bus10.UP  = up;
    bus10.DIN = din;
  endtask

  task automatic cyc();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    REnot = 1'b0;
    bus10.LD = 1'b0; bus10.EN = 1'b1; bus10.UP = 1'b1; bus10.DIN = 4'd0;
    bus16.LD = 1'b0; bus16.EN = 1'b0; bus16.UP = 1'b1; bus16.DIN = 4'd0;
    busb.LD = 1'b0; busb.UP = 1'b1; busb.DIN = 4'd0;
    cyc();
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd0) begin n_bad++; $display("FAIL reset_q: got %0d want 0", bus10.Q); end
    n_cmp++;
    if (bus10.Qnot !== 4'hF) begin n_bad++; $display("FAIL reset_qnot: got %h want f", bus10.Qnot); end
    n_cmp++;
    if (bus10.TC !== 1'b0) begin n_bad++; $display("FAIL reset_tc: got %b want 0", bus10.TC); end
    @(negedge C);
    REnot = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (bus10.Q !== 4'd3) begin n_bad++; $display("FAIL reset_release_count: got %0d want 3", bus10.Q); end
    n_cmp++;
    if (bus10.Qnot !== 4'hC) begin n_bad++; $display("FAIL reset_release_qnot: got %h want c", bus10.Qnot); end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_q[3];
    logic       exp_tc[3];
    exp_q  = '{4'd8, 4'd9, 4'd0};
    exp_tc = '{1'b0, 1'b1, 1'b0};
    drv(1'b1, 1'b0, 1'b1, 4'd7);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd7) begin n_bad++; $display("FAIL up_load7: got %0d want 7", bus10.Q); end
    drv(1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (bus10.Q !== exp_q[i]) begin n_bad++; $display("FAIL up_wrap_q[%0d]: got %0d want %0d", i, bus10.Q, exp_q[i]); end
      n_cmp++;
      if (bus10.TC !== exp_tc[i]) begin n_bad++; $display("FAIL up_wrap_tc[%0d]: got %b want %b", i, bus10.TC, exp_tc[i]); end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q[3];
    logic       exp_tc[3];
    exp_q  = '{4'd0, 4'd9, 4'd8};
    exp_tc = '{1'b1, 1'b0, 1'b0};
    drv(1'b1, 1'b0, 1'b0, 4'd1);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd1) begin n_bad++; $display("FAIL down_load1: got %0d want 1", bus10.Q); end
    drv(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (bus10.Q !== exp_q[i]) begin n_bad++; $display("FAIL down_wrap_q[%0d]: got %0d want %0d", i, bus10.Q, exp_q[i]); end
      n_cmp++;
      if (bus10.TC !== exp_tc[i]) begin n_bad++; $display("FAIL down_wrap_tc[%0d]: got %b want %b", i, bus10.TC, exp_tc[i]); end
    end
  endtask

  task automatic test_load_priority();
    drv(1'b1, 1'b1, 1'b1, 4'd5);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd5) begin n_bad++; $display("FAIL load_over_en: got %0d want 5", bus10.Q); end
    drv(1'b1, 1'b0, 1'b1, 4'd12);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd0) begin n_bad++; $display("FAIL load_range12: got %0d want 0", bus10.Q); end
    drv(1'b1, 1'b0, 1'b1, 4'd10);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd0) begin n_bad++; $display("FAIL load_range10: got %0d want 0", bus10.Q); end
    drv(1'b1, 1'b0, 1'b1, 4'd9);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd9) begin n_bad++; $display("FAIL load_max9: got %0d want 9", bus10.Q); end
    drv(1'b0, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if (bus10.Q !== 4'd9) begin n_bad++; $display("FAIL hold[%0d]: got %0d want 9", i, bus10.Q); end
    end
    n_cmp++;
    if (bus10.TC !== 1'b0) begin n_bad++; $display("FAIL hold_tc: got %b want 0", bus10.TC); end
  endtask

  task automatic test_dir_change();
    // Q is 9 here
    drv(1'b0, 1'b1, 1'b1, 4'd0);
    #1;
    n_cmp++;
    if (bus10.TC !== 1'b1) begin n_bad++; $display("FAIL dir_tc_up: got %b want 1", bus10.TC); end
    bus10.UP = 1'b0;
    #1;
    n_cmp++;
    if (bus10.TC !== 1'b0) begin n_bad++; $display("FAIL dir_tc_drop: got %b want 0", bus10.TC); end
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd8) begin n_bad++; $display("FAIL dir_step_down: got %0d want 8", bus10.Q); end
  endtask

  task automatic test_async_reset();
    drv(1'b1, 1'b0, 1'b1, 4'd5);
    cyc();
    drv(1'b0, 1'b1, 1'b1, 4'd0);
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd6) begin n_bad++; $display("FAIL async_pre: got %0d want 6", bus10.Q); end
    @(negedge C);
    REnot = 1'b0;
    #1;
    n_cmp++;
    if (bus10.Q !== 4'd0) begin n_bad++; $display("FAIL async_clear: got %0d want 0", bus10.Q); end
    n_cmp++;
    if (bus10.Qnot !== 4'hF) begin n_bad++; $display("FAIL async_qnot: got %h want f", bus10.Qnot); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++;
      if (bus10.Q !== 4'd0) begin n_bad++; $display("FAIL async_held[%0d]: got %0d want 0", i, bus10.Q); end
    end
    @(negedge C);
    REnot = 1'b1;
    cyc();
    n_cmp++;
    if (bus10.Q !== 4'd1) begin n_bad++; $display("FAIL async_resume: got %0d want 1", bus10.Q); end
  endtask

  task automatic test_mod16_chain();
    @(negedge C);
    bus16.LD = 1'b1; bus16.EN = 1'b0; bus16.UP = 1'b1; bus16.DIN = 4'd14;
    busb.LD = 1'b1; busb.UP = 1'b1; busb.DIN = 4'd0;
    cyc();
    @(negedge C);
    bus16.LD = 1'b0; bus16.EN = 1'b1;
    busb.LD = 1'b0;
    #1;
    n_cmp++;
    if (bus16.TC !== 1'b0) begin n_bad++; $display("FAIL m16_tc14: got %b want 0", bus16.TC); end
    cyc();
    n_cmp++;
    if (bus16.Q !== 4'd15) begin n_bad++; $display("FAIL m16_q15: got %0d want 15", bus16.Q); end
    n_cmp++;
    if (bus16.TC !== 1'b1) begin n_bad++; $display("FAIL m16_tc15: got %b want 1", bus16.TC); end
    n_cmp++;
    if (busb.Q !== 4'd0) begin n_bad++; $display("FAIL m16_hi_before: got %0d want 0", busb.Q); end
    cyc();
    n_cmp++;
    if (bus16.Q !== 4'd0) begin n_bad++; $display("FAIL m16_wrap: got %0d want 0", bus16.Q); end
    n_cmp++;
    if (busb.Q !== 4'd1) begin n_bad++; $display("FAIL m16_hi_first: got %0d want 1", busb.Q); end
    for (int i = 0; i < 15; i++) cyc();
    n_cmp++;
    if (busb.Q !== 4'd1) begin n_bad++; $display("FAIL m16_hi_15edges: got %0d want 1", busb.Q); end
    n_cmp++;
    if (bus16.Q !== 4'd15) begin n_bad++; $display("FAIL m16_lo_15edges: got %0d want 15", bus16.Q); end
    cyc();
    n_cmp++;
    if (busb.Q !== 4'd2) begin n_bad++; $display("FAIL m16_hi_16edges: got %0d want 2", busb.Q); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_dir_change();
    test_async_reset();
    test_mod16_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
